operand_sel_stage: RTL

- Parametrised, pipelined successor to the ALU source-B selector.
- Selects one of NUM_IN operand words and registers the result behind a valid/ready handshake, with a 2-entry skid buffer for full throughput.
- Out-of-range selects produce zero data plus per-beat and sticky error flags.
- Sits between decode/forwarding and the ALU operand port in the pipelined core.

---
 rtl/operand_sel_stage_pkg.sv | 16 +
 rtl/operand_sel_stage_mux_n.sv | 30 +++
 rtl/operand_sel_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/operand_sel_stage_pkg.sv
// Shared core definitions: handshake stage state encoding and select-width helper
// used by the operand selectors.
package operand_sel_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Select width for an N-way selector; never narrower than one bit.
  function automatic int sel_width(input int num_in);
    return (num_in <= 1) ? 1 : $clog2(num_in);
  endfunction

endpackage

// File: rtl/operand_sel_stage_mux_n.sv
// Purely combinational N-way word selector with an out-of-range flag.
// Out-of-range selects return all-zero data.
module mux_n
  import operand_sel_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data,
  output logic                    sel_err
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    data    = '0;
    sel_err = 1'b1;
    // With NUM_IN a power of two every sel value matches, so sel_err folds to 0.
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data    = in_bus[k*WIDTH +: WIDTH];
        sel_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/operand_sel_stage.sv
// ALU source-B operand selector: N-way select evaluated at the input, registered
// behind a valid/ready handshake with a 2-entry skid buffer for full throughput.
module operand_sel_stage
  import operand_sel_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_sticky,
  input  logic                    err_clear
);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } beat_t;

  stage_state_e state_q, state_d;
  beat_t        new_beat, main_q, skid_q;
  logic         in_ready_q, err_sticky_q;
  logic         accept, load_main, load_skid, skid_to_main;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .in_bus  (in_bus),
    .sel     (in_sel),
    .data    (new_beat.data),
    .sel_err (new_beat.err)
  );

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d      = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b1;
      // NOTE: the data registers are reset too, since out_data must read zero
      // during reset rather than whatever the last beat left behind.
      main_q       <= '0;
      skid_q       <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (load_main) begin
        main_q <= new_beat;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= new_beat;
      end
      // Set on acceptance of an illegal beat; set beats a same-edge clear.
      if (accept && new_beat.err) begin
        err_sticky_q <= 1'b1;
      end else if (err_clear) begin
        err_sticky_q <= 1'b0;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign out_data    = main_q.data;
  assign out_sel_err = main_q.err;
  assign err_sticky  = err_sticky_q;

endmodule
